grey_scan_ctrl: RTL

- Display scan controller for the 9-digit one-step-code decimal counter bundle (45 bits: ones at [4:0], tens at [9:5], ... hunM at [44:40]).
- Snapshots the whole bundle once per frame so the display never shows a torn value.
- Decodes each 5-bit digit code to its decimal value and time-multiplexes the digits onto one 7-segment output with a digit index.
- Sits between the counter and the chip output pins.

---
 rtl/grey_scan_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/grey_scan_ctrl.sv
// Display scan controller: snapshots a 9-digit one-step-code bundle once per frame
// and time-multiplexes the decoded digits onto one 7-segment output.
// Optional leading-zero blanking is enabled with the GREY_SCAN_LZB_EN macro.
module grey_scan_ctrl #(
  parameter int DWELL      = 4,
  parameter int NUM_DIGITS = 9
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [44:0] i_digits,
  input  logic        i_hold,
  output logic [6:0]  o_seg,
  output logic [3:0]  o_dig_sel,
  output logic        o_frame_start,
  output logic        o_err
);

  typedef enum logic [1:0] {SNAP, SHOW, BLANK} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [3:0] IDX_LAST   = 4'(NUM_DIGITS - 1);

  state_t      state;
  logic [3:0]  idx;
  logic [7:0]  cnt;
  logic [44:0] snap;

  function automatic logic [4:0] code_at(input logic [44:0] s, input logic [3:0] k);
    logic [4:0] c;
    c = '0;
    for (int j = 0; j < 9; j++)
      if (int'(k) == j) c = s[5*j +: 5];
    return c;
  endfunction

  // Returns {invalid, value}
  function automatic logic [4:0] decode(input logic [4:0] c);
    case (c)
      5'b00000: return {1'b0, 4'd0};
      5'b00001: return {1'b0, 4'd1};
      5'b00011: return {1'b0, 4'd2};
      5'b00010: return {1'b0, 4'd3};
      5'b00110: return {1'b0, 4'd4};
      5'b00100: return {1'b0, 4'd5};
      5'b01100: return {1'b0, 4'd6};
      5'b01000: return {1'b0, 4'd7};
      5'b11000: return {1'b0, 4'd8};
      5'b10000: return {1'b0, 4'd9};
      default:  return {1'b1, 4'd0};
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      default: return 7'h6F;
    endcase
  endfunction

`ifdef GREY_SCAN_LZB_EN
  // True when digits k..NUM_DIGITS-1 are all the valid zero code
  function automatic logic zero_tail(input logic [44:0] s, input logic [3:0] k);
    logic z;
    z = 1'b1;
    for (int j = 0; j < 9; j++)
      if (j >= int'(k) && j < NUM_DIGITS && s[5*j +: 5] != 5'b00000) z = 1'b0;
    return z;
  endfunction
`endif

  // Returns {err, seg} for digit k of bundle s
  function automatic logic [7:0] show_word(input logic [44:0] s, input logic [3:0] k);
    logic [4:0] d;
    d = decode(code_at(s, k));
`ifdef GREY_SCAN_LZB_EN
    if (k != 4'd0 && zero_tail(s, k)) return 8'h00;
`endif
    if (d[4]) return {1'b1, 7'h79};
    return {1'b0, seg_of(d[3:0])};
  endfunction

  // Outputs are computed from the next state so they line up with the state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= SNAP;
      idx           <= '0;
      cnt           <= '0;
      snap          <= '0;
      o_seg         <= '0;
      o_dig_sel     <= '0;
      o_frame_start <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_frame_start <= 1'b0;
      case (state)
        SNAP: begin
          if (!i_hold) snap <= i_digits;
          {o_err, o_seg} <= show_word(i_hold ? snap : i_digits, 4'd0);
          idx           <= '0;
          cnt           <= '0;
          o_dig_sel     <= '0;
          o_frame_start <= 1'b1;
          state         <= SHOW;
        end
        SHOW: begin
          if (cnt == DWELL_LAST) begin
            cnt   <= '0;
            o_seg <= '0;
            o_err <= 1'b0;
            state <= BLANK;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        BLANK: begin
          if (idx == IDX_LAST) begin
            state <= SNAP;
          end else begin
            idx            <= idx + 4'd1;
            o_dig_sel      <= idx + 4'd1;
            {o_err, o_seg} <= show_word(snap, idx + 4'd1);
            state          <= SHOW;
          end
        end
        default: state <= SNAP;
      endcase
    end
  end

endmodule
